// File: rtl/steer_delay_bank.sv
`default_nettype none
// ============================================================================
// Module      : steer_delay_bank
// Description : Per-channel steering delay bank for the mic-array beamformer.
//               Each of NUM_CH PCM streams is delayed by a run-time
//               programmable number of samples (0 .. MAX_DELAY-1). Each
//               channel has its own circular buffer, and all channels share
//               one write pointer. Delays are written into a shadow table
//               and copied to the active table in one cycle on cfg_commit.
//               A steering change therefore never mixes old and new delays
//               within one sample set.
//
//               Optional feature : define DELAY_SUM_EN to add the sum_out
//                                  port. It carries the registered,
//                                  sign-extended delay-and-sum of all
//                                  channels.
//
// Ports       : clk          - system clock
//               rst          - synchronous reset, active low
//               sample_valid - strobe, pcm_in holds a new sample set
//               pcm_in       - packed input, channel c at [c*DATA_W +: DATA_W]
//               cfg_wr       - write shadow delay cfg_delay for channel cfg_ch
//               cfg_ch       - channel index for cfg_wr
//               cfg_delay    - requested delay (clamped to MAX_DELAY-1)
//               cfg_commit   - copy shadow table to active table
//               pcm_out      - packed delayed samples (registered)
//               out_valid    - strobe, pcm_out updated this cycle
//               cfg_err      - pulse, previous cfg_wr was clamped or rejected
//               sum_out      - channel sum (DELAY_SUM_EN only)
//
// Revision    : 1.0 - initial release
// ============================================================================
module steer_delay_bank #(
    parameter int NUM_CH    = 8,
    parameter int DATA_W    = 19,
    parameter int MAX_DELAY = 32,
    parameter int DLY_W     = $clog2(MAX_DELAY)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sample_valid,
    input  logic [NUM_CH*DATA_W-1:0]           pcm_in,
    input  logic                               cfg_wr,
    input  logic [$clog2(NUM_CH)-1:0]          cfg_ch,
    input  logic [DLY_W:0]                     cfg_delay,
    input  logic                               cfg_commit,
    output logic [NUM_CH*DATA_W-1:0]           pcm_out,
    output logic                               out_valid,
    output logic                               cfg_err
`ifdef DELAY_SUM_EN
    ,
    output logic [DATA_W+$clog2(NUM_CH)-1:0]   sum_out
`endif
);

    localparam int              CH_W     = $clog2(NUM_CH);
    localparam logic [CH_W:0]   c_num_ch = (CH_W+1)'(NUM_CH);

    logic [DLY_W-1:0]           r_wp;
    logic [DLY_W-1:0]           r_fill;
    logic [DLY_W-1:0]           r_shadow     [NUM_CH];
    logic [DLY_W-1:0]           r_active     [NUM_CH];
    logic [DLY_W-1:0]           w_shadow_nxt [NUM_CH];
    logic [NUM_CH*DATA_W-1:0]   w_out;
    logic [NUM_CH*DATA_W-1:0]   r_pcm_out;
    logic                       r_out_valid;
    logic                       r_cfg_err;
    logic                       w_ch_bad;
    logic                       w_dly_clamp;

    // Shadow table next state. A write in the same cycle as a commit is
    // visible to the commit, so the active table loads from this next state.
    // MAX_DELAY is a power of two, so cfg_delay >= MAX_DELAY is its MSB.
    always_comb begin
        w_ch_bad    = cfg_wr && ({1'b0, cfg_ch} >= c_num_ch);
        w_dly_clamp = cfg_wr && !w_ch_bad && cfg_delay[DLY_W];
        for (int c = 0; c < NUM_CH; c++) begin
            w_shadow_nxt[c] = r_shadow[c];
            if (cfg_wr && !w_ch_bad && (cfg_ch == CH_W'(c))) begin
                w_shadow_nxt[c] = cfg_delay[DLY_W] ? {DLY_W{1'b1}} : cfg_delay[DLY_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wp        <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_pcm_out   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_shadow[c] <= '0;
                r_active[c] <= '0;
            end
        end else begin
            r_out_valid <= sample_valid;
            r_cfg_err   <= w_ch_bad || w_dly_clamp;
            for (int c = 0; c < NUM_CH; c++) begin
                r_shadow[c] <= w_shadow_nxt[c];
                if (cfg_commit) begin
                    r_active[c] <= w_shadow_nxt[c];
                end
            end
            if (sample_valid) begin
                r_pcm_out <= w_out;
                r_wp      <= r_wp + 1'b1;
                // Fill saturates at MAX_DELAY-1 (all ones).
                if (r_fill != {DLY_W{1'b1}}) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    genvar gc;
    generate
        for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
            logic [DATA_W-1:0] r_buf [MAX_DELAY];
            logic [DATA_W-1:0] w_in;
            logic [DATA_W-1:0] w_dly;
            logic [DLY_W-1:0]  w_rd_idx;

            assign w_in     = pcm_in[gc*DATA_W +: DATA_W];
            // Modulo MAX_DELAY comes from the natural DLY_W-bit wrap.
            assign w_rd_idx = r_wp - r_active[gc];
            // Entries older than the fill count are stale after reset and
            // read as silence.
            assign w_dly    = (r_active[gc] == '0)    ? w_in :
                              (r_active[gc] > r_fill) ? '0   :
                                                        r_buf[w_rd_idx];
            assign w_out[gc*DATA_W +: DATA_W] = w_dly;

            // The buffer is not reset. The fill count masks its contents.
            always_ff @(posedge clk) begin
                if (rst && sample_valid) begin
                    r_buf[r_wp] <= w_in;
                end
            end
        end
    endgenerate

    assign pcm_out   = r_pcm_out;
    assign out_valid = r_out_valid;
    assign cfg_err   = r_cfg_err;

`ifdef DELAY_SUM_EN
    localparam int SUM_W = DATA_W + CH_W;

    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] r_sum;

    // The CH_W guard bits make overflow impossible.
    always_comb begin
        w_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_sum = w_sum + {{CH_W{w_out[c*DATA_W+DATA_W-1]}}, w_out[c*DATA_W +: DATA_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sum <= '0;
        end else if (sample_valid) begin
            r_sum <= w_sum;
        end
    end

    assign sum_out = r_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_steer_delay_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_steer_delay_bank
// Description : Self-checking bench for steer_delay_bank. It uses directed
//               and randomised stimulus and compares the outputs against a
//               sample-history reference model. A second, small instance
//               exercises rejection of an out-of-range channel index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_steer_delay_bank;

    localparam int NUM_CH    = 8;
    localparam int DATA_W    = 19;
    localparam int MAX_DELAY = 32;
    localparam int W         = NUM_CH * DATA_W;
    localparam int SUM_W     = DATA_W + 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           sample_valid = 1'b0;
    logic [W-1:0]   pcm_in = '0;
    logic           cfg_wr = 1'b0;
    logic [2:0]     cfg_ch = '0;
    logic [5:0]     cfg_delay = '0;
    logic           cfg_commit = 1'b0;
    logic [W-1:0]   pcm_out;
    logic           out_valid;
    logic           cfg_err;
`ifdef DELAY_SUM_EN
    logic [SUM_W-1:0] sum_out;
`endif

    // Small instance: 3 channels, so that cfg_ch == 3 is out of range.
    logic           s_rst = 1'b0;
    logic           s_sv = 1'b0;
    logic [23:0]    s_pcm_in = '0;
    logic           s_wr = 1'b0;
    logic [1:0]     s_ch = '0;
    logic [2:0]     s_dly = '0;
    logic           s_commit = 1'b0;
    logic [23:0]    s_pcm_out;
    logic           s_out_valid;
    logic           s_cfg_err;
`ifdef DELAY_SUM_EN
    logic [9:0]     s_sum;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int             sh  [NUM_CH];
    int             act [NUM_CH];
    int             n_smp;
    logic [W-1:0]   hist [$];
    logic [W-1:0]   exp_pcm;

    always #5 clk = ~clk;

    steer_delay_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_DELAY(MAX_DELAY)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .pcm_in(pcm_in),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_commit(cfg_commit),
        .pcm_out(pcm_out), .out_valid(out_valid), .cfg_err(cfg_err)
`ifdef DELAY_SUM_EN
        , .sum_out(sum_out)
`endif
    );

    steer_delay_bank #(.NUM_CH(3), .DATA_W(8), .MAX_DELAY(4)) dut_s (
        .clk(clk), .rst(s_rst), .sample_valid(s_sv), .pcm_in(s_pcm_in),
        .cfg_wr(s_wr), .cfg_ch(s_ch), .cfg_delay(s_dly), .cfg_commit(s_commit),
        .pcm_out(s_pcm_out), .out_valid(s_out_valid), .cfg_err(s_cfg_err)
`ifdef DELAY_SUM_EN
        , .sum_out(s_sum)
`endif
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ramp(input int k);
        logic [W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*DATA_W +: DATA_W] = DATA_W'(k);
        return v;
    endfunction

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    function automatic logic [SUM_W-1:0] model_sum(input logic [W-1:0] v);
        int s;
        logic signed [DATA_W-1:0] t;
        s = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            t = v[c*DATA_W +: DATA_W];
            s += t;
        end
        return SUM_W'(s);
    endfunction

    task automatic check_outputs(input logic e_valid, input logic e_err);
        check("out_valid", {255'd0, out_valid}, {255'd0, e_valid});
        check("cfg_err", {255'd0, cfg_err}, {255'd0, e_err});
        check("pcm_out", 256'(pcm_out), 256'(exp_pcm));
`ifdef DELAY_SUM_EN
        check("sum_out", 256'(sum_out), 256'(model_sum(exp_pcm)));
`endif
    endtask

    // One clock of stimulus. The model output is the sample from d samples
    // ago, or silence if fewer than d samples were seen since reset
    // (capped at MAX_DELAY-1).
    task automatic cycle(input logic sv, input logic [W-1:0] pin, input logic wr,
                         input logic [2:0] ch, input logic [5:0] dly, input logic cm);
        logic         e_err;
        int           fill;
        int           d;
        logic [W-1:0] past;
        sample_valid = sv; pcm_in = pin; cfg_wr = wr;
        cfg_ch = ch; cfg_delay = dly; cfg_commit = cm;
        if (sv) begin
            fill = (n_smp < MAX_DELAY-1) ? n_smp : MAX_DELAY-1;
            for (int c = 0; c < NUM_CH; c++) begin
                d = act[c];
                if (d == 0) begin
                    exp_pcm[c*DATA_W +: DATA_W] = pin[c*DATA_W +: DATA_W];
                end else if (d > fill) begin
                    exp_pcm[c*DATA_W +: DATA_W] = '0;
                end else begin
                    past = hist[n_smp - d];
                    exp_pcm[c*DATA_W +: DATA_W] = past[c*DATA_W +: DATA_W];
                end
            end
        end
        e_err = wr && ((int'(ch) >= NUM_CH) || (int'(dly) >= MAX_DELAY));
        if (wr && int'(ch) < NUM_CH) sh[ch] = (int'(dly) >= MAX_DELAY) ? MAX_DELAY-1 : int'(dly);
        if (cm) act = sh;
        if (sv) begin
            hist.push_back(pin);
            n_smp++;
        end
        @(posedge clk); #1;
        check_outputs(sv, e_err);
    endtask

    task automatic do_reset(input logic sv);
        rst = 1'b0; sample_valid = sv; pcm_in = rnd_vec();
        cfg_wr = 1'b0; cfg_commit = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; sample_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            sh[c] = 0;
            act[c] = 0;
        end
        n_smp = 0;
        hist.delete();
        exp_pcm = '0;
        check_outputs(1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] vmin;
        int           k;

        // Reset state.
        do_reset(1'b0);

        // All delays zero: pass-through ramp.
        for (int i = 0; i < 40; i++) cycle(1'b1, ramp(i), 1'b0, 3'd0, 6'd0, 1'b0);

        // Delays 2c from a fresh reset, ramp input.
        do_reset(1'b0);
        for (int c = 0; c < NUM_CH; c++) cycle(1'b0, '0, 1'b1, 3'(c), 6'(2*c), 1'b0);
        cycle(1'b0, '0, 1'b0, 3'd0, 6'd0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b1, ramp(i), 1'b0, 3'd0, 6'd0, 1'b0);

        // Out-of-range delay is clamped to MAX_DELAY-1.
        cycle(1'b0, '0, 1'b1, 3'd3, 6'd40, 1'b0);
        cycle(1'b0, '0, 1'b0, 3'd0, 6'd0, 1'b1);
        for (int i = 40; i < 50; i++) cycle(1'b1, ramp(i), 1'b0, 3'd0, 6'd0, 1'b0);

        // Commit coincident with a sample uses the old table for that sample.
        cycle(1'b0, '0, 1'b1, 3'd1, 6'd0, 1'b1);
        cycle(1'b1, ramp(50), 1'b0, 3'd0, 6'd0, 1'b0);
        cycle(1'b0, '0, 1'b1, 3'd1, 6'd5, 1'b0);
        cycle(1'b1, ramp(51), 1'b0, 3'd0, 6'd0, 1'b1);
        cycle(1'b1, ramp(52), 1'b0, 3'd0, 6'd0, 1'b0);

        // Maximum delay across several pointer wraps.
        for (int c = 0; c < NUM_CH; c++) cycle(1'b0, '0, 1'b1, 3'(c), 6'd31, 1'b0);
        cycle(1'b0, '0, 1'b0, 3'd0, 6'd0, 1'b1);
        for (int i = 0; i < 100; i++) cycle(1'b1, rnd_vec(), 1'b0, 3'd0, 6'd0, 1'b0);

        // Randomised mix of samples, writes and commits.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), rnd_vec(), 1'($urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 7) == 0));
        end

        // Most negative samples on every channel, then reset mid-stream.
        do_reset(1'b0);
        for (int c = 0; c < NUM_CH; c++) vmin[c*DATA_W +: DATA_W] = {1'b1, {(DATA_W-1){1'b0}}};
        cycle(1'b1, vmin, 1'b0, 3'd0, 6'd0, 1'b0);
`ifdef DELAY_SUM_EN
        check("sum_min", 256'(sum_out), 256'(SUM_W'(-2097152)));
`endif
        cycle(1'b1, vmin, 1'b0, 3'd0, 6'd0, 1'b0);
        do_reset(1'b1);
        cycle(1'b0, '0, 1'b0, 3'd0, 6'd0, 1'b0);

        // Small instance: rejected channel index and clamped delay.
        s_rst = 1'b0;
        @(posedge clk); #1;
        check("s_reset_valid", {255'd0, s_out_valid}, 256'd0);
        s_rst = 1'b1;
        s_wr = 1'b1; s_ch = 2'd3; s_dly = 3'd1;
        @(posedge clk); #1;
        check("s_err_bad_ch", {255'd0, s_cfg_err}, 256'd1);
        s_ch = 2'd0; s_dly = 3'd5; s_commit = 1'b1;
        @(posedge clk); #1;
        check("s_err_clamp", {255'd0, s_cfg_err}, 256'd1);
        s_wr = 1'b0; s_commit = 1'b0;
        @(posedge clk); #1;
        check("s_err_idle", {255'd0, s_cfg_err}, 256'd0);
        for (int i = 1; i <= 6; i++) begin
            s_sv = 1'b1;
            s_pcm_in = {3{8'(i)}};
            @(posedge clk); #1;
            k = (i > 3) ? i - 3 : 0;
            check("s_ch0_dly3", 256'(s_pcm_out[7:0]), 256'(k));
            check("s_ch1_dly0", 256'(s_pcm_out[15:8]), 256'(i));
            check("s_ch2_dly0", 256'(s_pcm_out[23:16]), 256'(i));
        end
        s_sv = 1'b0;
        @(posedge clk); #1;
        check("s_valid_low", {255'd0, s_out_valid}, 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
